// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB memory slave.
package apb_slv_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned log2_ceil(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x DATA_WIDTH word store: synchronous clear, byte-lane writes, combinational read.
module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                               clk,
    input  logic                               clr,
    input  logic                               we,
    input  logic [DATA_WIDTH/8-1:0]            be,
    input  logic [log2_ceil(DEPTH)-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]              wdata,
    output logic [DATA_WIDTH-1:0]              rdata
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave with word memory, programmable wait states and PSLVERR.
// Byte-lane strobes (PSTRB) are enabled by defining APB_SLV_PSTRB_EN.
module apb_mem_slave
    import apb_slv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned LSB   = log2_ceil(BYTES);
    localparam int unsigned IDX_W = log2_ceil(DEPTH);

    apb_state_e              state, next_state;
    logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                    load_out;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    addr_err;
    logic [BYTES-1:0]        byte_en;
    logic [DATA_WIDTH-1:0]   rd_data;

    // Misaligned byte offset or word index past the end of the array.
    assign word_idx = PADDR >> LSB;
    assign addr_err = ((PADDR & ADDR_WIDTH'(BYTES - 1)) != '0)
                    || (64'(word_idx) >= 64'(DEPTH));

`ifdef APB_SLV_PSTRB_EN
    assign byte_en = PSTRB;
`else
    assign byte_en = '1;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        next_state   = state;
        wait_cnt_nxt = wait_cnt;
        load_out     = 1'b0;
        mem_we       = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    wait_cnt_nxt = WAIT_CNT_W'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        next_state = WAIT;
                    end else begin
                        next_state = READY;
                        load_out   = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Dropping PSEL mid-transfer abandons it silently.
                if (!PSEL) begin
                    next_state = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - WAIT_CNT_W'(1);
                    if (wait_cnt == WAIT_CNT_W'(1)) begin
                        next_state = READY;
                        load_out   = 1'b1;
                    end
                end
            end
            READY: begin
                next_state = IDLE;
                mem_we     = PSEL && PENABLE && PWRITE && !addr_err;
            end
            default: next_state = IDLE;
        endcase
    end

    // Response registers; PSLVERR pulses only alongside PREADY.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else begin
            PSLVERR <= load_out && addr_err;
            if (load_out && !PWRITE) PRDATA <= addr_err ? '0 : rd_data;
        end
    end

    assign PREADY = (state == READY);

    apb_slv_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_regfile (
        .clk   (PCLK),
        .clr   (PRESET),
        .we    (mem_we),
        .be    (byte_en),
        .addr  (word_idx[IDX_W-1:0]),
        .wdata (PWDATA),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: zero-wait and 3-wait-state instances on a shared bus.
module tb_apb_mem_slave;

    logic        clk;
    logic        preset;
    logic        psel0, psel3;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready0, pslverr0, pready3, pslverr3;
    logic [31:0] prdata0, prdata3;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    apb_mem_slave #(.WAIT_STATES(0)) u0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_SLV_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0)
    );

    apb_mem_slave #(.WAIT_STATES(3)) u3 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_SLV_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Setup then access; returns at the PREADY cycle so a following call is back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err, output int cyc);
        @(posedge clk); #1;
        psel0 = (d == 0); psel3 = (d == 3);
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 2;
        while (!((d == 0) ? pready0 : pready3) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        rd  = (d == 0) ? prdata0 : prdata3;
        err = (d == 0) ? pslverr0 : pslverr3;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          cyc;
    logic        bad;

    initial begin
        vecs[0]  = '{1'b0, 32'h14,  32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h100, 32'h12345678, 32'hDEADBEEF, 1'b1};
        vecs[4]  = '{1'b1, 32'h11,  32'hCAFEF00D, 32'hDEADBEEF, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,   32'h0,        32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b0, 32'h100, 32'h0,        32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'hFC,  32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'hFC,  32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b1, 32'h0,   32'h11223344, 32'h0,        1'b0};

        preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = 4'hF;
        repeat (3) @(posedge clk);
        #1 preset = 1'b0;

        chk("rst pready0", 64'(pready0), 64'd0);
        chk("rst prdata0", 64'(prdata0), 64'd0);
        chk("rst pslverr0", 64'(pslverr0), 64'd0);
        chk("rst pready3", 64'(pready3), 64'd0);

        // Zero-wait table, all transfers back to back.
        for (int i = 0; i < 12; i++) begin
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, rd, err, cyc);
            chk($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            chk($sformatf("v%0d cycles", i), 64'(cyc), 64'd2);
        end
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, err, cyc);
        chk("raw word0", 64'(rd), 64'h11223344);
        idle();
        chk("pready0 one cycle", 64'(pready0), 64'd0);

`ifdef APB_SLV_PSTRB_EN
        xfer(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, rd, err, cyc);
        chk("strb wr err", 64'(err), 64'd0);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'b0000, rd, err, cyc);
        chk("strb readback", 64'(rd), 64'h11BB33DD);
        xfer(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000, rd, err, cyc);
        chk("strb zero err", 64'(err), 64'd0);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, err, cyc);
        chk("strb zero unchanged", 64'(rd), 64'h11BB33DD);
        idle();
`endif

        // Three wait states: 5 cycles from setup, PREADY single-cycle.
        xfer(3, 1'b1, 32'h10, 32'h000055AA, 4'hF, rd, err, cyc);
        chk("ws3 wr cycles", 64'(cyc), 64'd5);
        xfer(3, 1'b0, 32'h10, 32'h0, 4'hF, rd, err, cyc);
        chk("ws3 rd cycles", 64'(cyc), 64'd5);
        chk("ws3 rd data", 64'(rd), 64'h55AA);
        chk("ws3 rd err", 64'(err), 64'd0);
        idle();
        chk("pready3 one cycle", 64'(pready3), 64'd0);

        // PSEL dropped during WAIT: no completion, no error, no write.
        @(posedge clk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h99;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel3 = 1'b0; penable = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (pready3 !== 1'b0 || pslverr3 !== 1'b0) bad = 1'b1;
        end
        chk("abort quiet", 64'(bad), 64'd0);
        xfer(3, 1'b0, 32'h24, 32'h0, 4'hF, rd, err, cyc);
        chk("abort no write", 64'(rd), 64'd0);
        idle();

        // Reset during WAIT of a write to 0x20.
        @(posedge clk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h12345678;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
        chk("mid rst pready3", 64'(pready3), 64'd0);
        chk("mid rst prdata3", 64'(prdata3), 64'd0);
        chk("mid rst pslverr3", 64'(pslverr3), 64'd0);
        chk("mid rst prdata0", 64'(prdata0), 64'd0);
        xfer(3, 1'b0, 32'h20, 32'h0, 4'hF, rd, err, cyc);
        chk("rst 0x20 data", 64'(rd), 64'd0);
        chk("rst 0x20 cycles", 64'(cyc), 64'd5);
        xfer(3, 1'b0, 32'h10, 32'h0, 4'hF, rd, err, cyc);
        chk("rst clears u3 mem", 64'(rd), 64'd0);
        idle();
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, err, cyc);
        chk("rst clears u0 mem", 64'(rd), 64'd0);
        idle();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB slave with on-chip word memory, programmable wait states, error response and byte-lane writes. Next generation of our fixed 32-bit, 64-word APB slave: generalised in data width, address width, depth and access latency, and adds PSLVERR for out-of-range or misaligned accesses. Sits behind the APB master/decoder as one PSEL target.

## Interface
- DATA_WIDTH, 32: PWDATA/PRDATA width; one of 8, 16, 32 or 64.
- ADDR_WIDTH, 32: PADDR width.
- DEPTH, 64: number of memory words, at least 2.
- WAIT_STATES, 0: PREADY-low cycles inserted per access, 0 to 15.
- PCLK  in  1  APB clock, rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte-lane write strobes. Present only with APB_SLV_PSTRB_EN.
- PREADY  out  1  transfer completes this cycle.
- PRDATA  out  DATA_WIDTH  read data; valid when PREADY=1 and PWRITE=0.
- PSLVERR  out  1  error response; valid only when PREADY=1.

## Operation
- BYTES = DATA_WIDTH/8. LSB = log2(BYTES). Word index = PADDR >> LSB.
- An access is in error when PADDR[LSB-1:0] != 0 (DATA_WIDTH > 8 only) or when the word index >= DEPTH.
- FSM states: IDLE, WAIT, READY.
  - IDLE: when PSEL=1 and PENABLE=0 (setup), load wait_cnt = WAIT_STATES. Go to WAIT if WAIT_STATES > 0, otherwise go to READY.
  - WAIT: decrement wait_cnt. On the edge where wait_cnt == 1, go to READY.
  - READY: always return to IDLE.
- PREADY = (state == READY).
- PRDATA and PSLVERR are registered and loaded on the edge that enters READY:
  - Read, no error: PRDATA = mem[index].
  - Read, error: PRDATA = 0.
  - Write: PRDATA keeps its previous value.
- The write commits on the edge leaving READY, only when PSEL, PENABLE and PWRITE are all 1 and there is no error. Errored writes leave memory untouched.
- Protocol violation: PSEL=0 while in WAIT or READY aborts the transfer. FSM goes to IDLE, no write, PSLVERR is not asserted.
- PADDR, PWRITE and PWDATA are held stable by the master through the transfer. The slave samples them on the committing edge.

## Timing
- Reset (PRESET high at a PCLK edge):
  - State IDLE, PREADY=0, PRDATA=0, PSLVERR=0, wait_cnt=0.
  - Every memory word cleared to 0.
  - Reset during WAIT or READY aborts the transfer with no write.
- Transfer length from setup to completion is 2 + WAIT_STATES cycles.
  - WAIT_STATES=0: PREADY is high in the first access cycle.
- PREADY is high for exactly one cycle per transfer.
- Back-to-back transfers: a setup may arrive in the cycle after READY. No bubble is needed beyond APB's mandatory setup cycle.
- Read-after-write to the same word in consecutive transfers returns the new data.

## Configuration
- APB_SLV_PSTRB_EN defined:
  - PSTRB port present.
  - A write updates only the byte lanes whose strobe bit is 1.
  - PSTRB is ignored on reads.
  - A write with PSTRB all zero completes with PSLVERR=0 and changes nothing.
- APB_SLV_PSTRB_EN undefined: PSTRB port absent and every write updates the full word.

## Structure
- Package apb_slv_pkg holds:
  - FSM state enum {IDLE, WAIT, READY}.
  - Shared helper function computing log2 for LSB and index widths.
  - WAIT_STATES counter width constant (4 bits).
- Sub-module apb_slv_regfile holds:
  - The DEPTH x DATA_WIDTH array.
  - Synchronous clear.
  - Per-byte write enable (all ones when APB_SLV_PSTRB_EN is undefined).
  - Combinational read port.
- The top level holds the FSM, wait counter, address decode/error check and output registers.

## Test plan
- Reset, then read word 5 with defaults -> PREADY high in the 2nd cycle, PRDATA=0, PSLVERR=0.
- Write 0xDEADBEEF to PADDR 0x10, then read 0x10 back to back -> PRDATA=0xDEADBEEF, each transfer 2 cycles.
- WAIT_STATES=3: read 0x10 -> PREADY low for 3 access cycles, then high for 1; total 5 cycles from setup.
- Write to PADDR 0x100 (index 64, DEPTH=64), and separately to PADDR 0x11 -> PSLVERR=1 with PREADY for each. Subsequent reads of words 0 and 4 are unchanged.
- APB_SLV_PSTRB_EN: word holds 0x11223344; write 0xAABBCCDD with PSTRB=4'b0101 -> readback 0x11BB33DD.
- Assert PRESET during WAIT of a write to 0x20 -> no write; after reset, reading 0x20 returns 0 and all outputs are at reset values.
